mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Control unit for the multicycle ARM-subset datapath. It decodes the latched instruction, steps through a Moore FSM, and drives every datapath select and enable. It also holds the NZCV condition flags and gates architectural writes through condition evaluation. It connects directly to the datapath's control inputs, to Instr[31:12] and to ALUFlags, and drives the memory MemWrite.

Parameters:
FETCH_ONLY_ON_RESET, 1, when 1 the FSM is forced to FETCH while reset is low (the only supported value; kept for lint symmetry)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (low = reset asserted)
Instr  in  20  Instr[31:12] from the instruction register: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0 = PC, 1 = Result onto the memory address
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register enable
RegSrc  out  2  [0] RA1 = R15, [1] RA2 = Rd
RegWrite  out  1  register file write enable
ImmSrc  out  2  extend select, equal to op
ALUSrcA  out  1  0 = register A, 1 = PC
ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult

Behaviour:
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- When reset is low: state = FETCH and Flags = 4'b0000, asynchronously. Outputs then take the FETCH decode.
- The first rising edge after reset deasserts performs the FETCH actions.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: op 00 with funct[5]=0 -> EXECR; op 00 with funct[5]=1 -> EXECI; op 01 -> MEMADR; op 10 -> BRANCH; op 11 -> FETCH (treated as NOP).
  - MEMADR: funct[0]=1 -> MEMREAD; funct[0]=0 -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECR and EXECI -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
- Moore outputs per state. Any control not listed is 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00 (funct[3]=U; U=0 selects SUB).
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, Branch=1.
- ALU decode, active only when ALUOp=1, on cmd = funct[4:1]:
  - 0100 -> 00, 0010 -> 01, 0000 -> 10, 1100 -> 11.
  - Any other cmd -> ALUControl 00, FlagW 00, NoWrite=1.
- Flag-write field FlagW[1:0] (NZ, CV), only when S = funct[0] = 1:
  - FlagW[1] = S.
  - FlagW[0] = S AND (cmd is ADD or SUB).
- Static decodes, independent of state:
  - RegSrc[0] = (op==10).
  - RegSrc[1] = (op==01).
  - ImmSrc = op.
- CondEx uses the registered Flags, decoded from cond:
  - EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - cond 1111 -> CondEx = 0.
- Flags update at the clock edge in EXECR/EXECI when CondEx=1: NZ when FlagW[1], CV when FlagW[0].
- Write gating:
  - PCS = (Rd==15 AND RegW) OR Branch.
  - PCWrite = NextPC OR (PCS AND CondEx).
  - RegWrite = RegW AND CondEx AND NOT NoWrite.
  - MemWrite = MemW AND CondEx.
- Latency in cycles: data-processing 4, LDR 5, STR 4, B 3, undefined op 2.
- Reset asserted in any state aborts the instruction immediately; no write enables are asserted after reset.

Optional Feature:
CTRL_CMP_EN.
- Defined: cmd 1010 with S=1 (CMP) gives ALUControl=01, FlagW=11, NoWrite=1. Flags update and RegWrite stays 0 in ALUWB.
- Undefined: cmd 1010 falls into the unsupported branch (ALUControl 00, FlagW 00, NoWrite=1), so CMP acts as a NOP.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state_t enum;
  - op constants (OP_DP=00, OP_MEM=01, OP_BR=10);
  - ALUControl encodings;
  - cond-code constants;
  - ResultSrc and ALUSrcB encodings.
- One sub-module, cond_unit, holds the Flags register, the CondEx decode and the write gating.

Test Plan:
- ADD R1,R2,R3 (0xE0821003) after reset -> FETCH, DECODE, EXECR, ALUWB; ALUControl=00 in EXECR; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- LDR R2,[R1,#4] (0xE5912004) -> 5-cycle path through MEMREAD and MEMWB; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB.
- STR R2,[R1,#4] (0xE5812004) -> MEMWRITE with MemWrite=1 and AdrSrc=1; RegWrite never asserted.
- SUBS R0,R0,R0 (0xE0500000) with ALUFlags=0100 in EXECR -> Flags=0100. Then ADDNE (0x10821003) reaches ALUWB with RegWrite=0, and ADDEQ (0x00821003) reaches ALUWB with RegWrite=1.
- B +8 (0xEA000001) -> FETCH, DECODE, BRANCH; RegSrc=01 in all three states; PCWrite=1 in BRANCH; ResultSrc=10.
- reset driven low during MEMREAD of an LDR -> state = FETCH and Flags = 0 without waiting for a clock edge; RegWrite and MemWrite stay 0; normal fetch resumes one edge after reset goes high.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multicycle ARM-subset control unit
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    // Instruction class in op[27:26]; 11 is executed as a NOP
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Data-processing cmd field funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes; 1111 is never executed
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flag register, condition evaluation and architectural write gating
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       next_pc,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex
);

    logic [3:0] flags;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    // Evaluate the instruction condition against the registered flags
    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flags: NZ and CV halves written independently; flag_w is only nonzero in EXECR/EXECI
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
        end
    end

    assign pc_write  = next_pc | (pcs & cond_ex);
    assign reg_write = reg_w & cond_ex & ~no_write;
    assign mem_write = mem_w & cond_ex;

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM-subset control FSM and decoders (CTRL_CMP_EN adds CMP)
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int FETCH_ONLY_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ResultSrc
);

    // Only FETCH is a supported reset state
    localparam state_t RESET_STATE = (FETCH_ONLY_ON_RESET == 1) ? FETCH : FETCH;

`ifdef CTRL_CMP_EN
    localparam logic [3:0] CMD_CMP = 4'b1010;
`endif

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       s_bit;
    logic       unused_instr;

    assign cond         = Instr[19:16];
    assign op           = Instr[15:14];
    assign funct        = Instr[13:8];
    assign rd           = Instr[3:0];
    assign cmd          = funct[4:1];
    assign s_bit        = funct[0];
    assign unused_instr = ^Instr[7:4];

    state_t     state, state_next;
    logic       next_pc, reg_w, mem_w, branch, alu_op;
    logic [1:0] main_alu_ctl;
    logic [1:0] dec_alu_ctl;
    logic [1:0] flag_w_dec;
    logic       no_write_dec;
    logic [1:0] flag_w;
    logic       no_write;
    logic       pcs;
    logic       cond_ex;

    // State register; reset aborts whatever instruction is in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RESET_STATE;
        else        state <= state_next;
    end

    // Next state and Moore control outputs
    always_comb begin
        state_next   = FETCH;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_WD;
        ResultSrc    = RES_ALUOUT;
        main_alu_ctl = ALU_ADD;
        next_pc      = 1'b0;
        reg_w        = 1'b0;
        mem_w        = 1'b0;
        branch       = 1'b0;
        alu_op       = 1'b0;
        unique case (state)
            FETCH: begin
                state_next = DECODE;
                IRWrite    = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                next_pc    = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                unique case (op)
                    OP_DP:   state_next = funct[5] ? EXECI : EXECR;
                    OP_MEM:  state_next = MEMADR;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                state_next   = funct[0] ? MEMREAD : MEMWRITE;
                ALUSrcB      = SRCB_IMM;
                // U bit clear means a subtracted offset
                main_alu_ctl = funct[3] ? ALU_ADD : ALU_SUB;
            end
            MEMREAD: begin
                state_next = MEMWB;
                AdrSrc     = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            EXECR: begin
                state_next = ALUWB;
                alu_op     = 1'b1;
            end
            EXECI: begin
                state_next = ALUWB;
                ALUSrcB    = SRCB_IMM;
                alu_op     = 1'b1;
            end
            ALUWB: begin
                reg_w = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // Data-processing decode of cmd/S; applied only where the FSM asks for it
    always_comb begin
        dec_alu_ctl  = ALU_ADD;
        flag_w_dec   = 2'b00;
        no_write_dec = 1'b0;
        unique case (cmd)
            CMD_ADD: begin
                dec_alu_ctl = ALU_ADD;
                flag_w_dec  = {s_bit, s_bit};
            end
            CMD_SUB: begin
                dec_alu_ctl = ALU_SUB;
                flag_w_dec  = {s_bit, s_bit};
            end
            CMD_AND: begin
                dec_alu_ctl = ALU_AND;
                flag_w_dec  = {s_bit, 1'b0};
            end
            CMD_ORR: begin
                dec_alu_ctl = ALU_ORR;
                flag_w_dec  = {s_bit, 1'b0};
            end
`ifdef CTRL_CMP_EN
            CMD_CMP: begin
                no_write_dec = 1'b1;
                if (s_bit) begin
                    dec_alu_ctl = ALU_SUB;
                    flag_w_dec  = 2'b11;
                end
            end
`endif
            default: no_write_dec = 1'b1;
        endcase
    end

    // NoWrite must still hold in ALUWB, so it follows the instruction class rather than alu_op
    assign ALUControl = alu_op ? dec_alu_ctl : main_alu_ctl;
    assign flag_w     = alu_op ? flag_w_dec : 2'b00;
    assign no_write   = (op == OP_DP) & no_write_dec;

    assign RegSrc[0] = (op == OP_BR);
    assign RegSrc[1] = (op == OP_MEM);
    assign ImmSrc    = op;

    assign pcs = ((rd == 4'd15) & reg_w) | branch;

    cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .next_pc   (next_pc),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .no_write  (no_write),
        .pc_write  (PCWrite),
        .reg_write (RegWrite),
        .mem_write (MemWrite),
        .cond_ex   (cond_ex)
    );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
    logic [15:0] ctl;

    int n_checks = 0;
    int n_fail   = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc)
    );

    assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegSrc, RegWrite, ImmSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ResultSrc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Pack an expected control vector in the same order as ctl
    function automatic logic [15:0] cv(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs, input logic rw,
                                       input logic [1:0] imm, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ac, input logic [1:0] res);
        return {pcw, adr, mw, irw, rs, rw, imm, sa, sb, ac, res};
    endfunction

    task automatic test_reset();
        logic [15:0] exp_f;
        exp_f = cv(1, 0, 0, 1, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 2'b10);
        reset    = 1'b0;
        Instr    = 20'hE0821;
        ALUFlags = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (ctl !== exp_f) begin
            n_fail++;
            $display("FAIL reset_ctl: got %h expected %h", ctl, exp_f);
        end
        n_checks++;
        if (dut.u_cond.flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", dut.u_cond.flags);
        end
        reset = 1'b1;
    endtask

    task automatic test_add();
        logic [15:0] exp_v [4];
        exp_v[0] = cv(1, 0, 0, 1, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 2'b10);
        exp_v[1] = cv(0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 2'b10);
        exp_v[2] = cv(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        exp_v[3] = cv(0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        Instr = 20'hE0821;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ctl !== exp_v[i]) begin
                n_fail++;
                $display("FAIL add cycle %0d: got %h expected %h", i, ctl, exp_v[i]);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_ldr();
        logic [15:0] exp_v [5];
        exp_v[0] = cv(1, 0, 0, 1, 2'b10, 0, 2'b01, 1, 2'b10, 2'b00, 2'b10);
        exp_v[1] = cv(0, 0, 0, 0, 2'b10, 0, 2'b01, 1, 2'b10, 2'b00, 2'b10);
        exp_v[2] = cv(0, 0, 0, 0, 2'b10, 0, 2'b01, 0, 2'b01, 2'b00, 2'b00);
        exp_v[3] = cv(0, 1, 0, 0, 2'b10, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00);
        exp_v[4] = cv(0, 0, 0, 0, 2'b10, 1, 2'b01, 0, 2'b00, 2'b00, 2'b01);
        Instr = 20'hE5912;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ctl !== exp_v[i]) begin
                n_fail++;
                $display("FAIL ldr cycle %0d: got %h expected %h", i, ctl, exp_v[i]);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_str();
        logic [15:0] exp_v [4];
        exp_v[0] = cv(1, 0, 0, 1, 2'b10, 0, 2'b01, 1, 2'b10, 2'b00, 2'b10);
        exp_v[1] = cv(0, 0, 0, 0, 2'b10, 0, 2'b01, 1, 2'b10, 2'b00, 2'b10);
        exp_v[2] = cv(0, 0, 0, 0, 2'b10, 0, 2'b01, 0, 2'b01, 2'b00, 2'b00);
        exp_v[3] = cv(0, 1, 1, 0, 2'b10, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00);
        Instr = 20'hE5812;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ctl !== exp_v[i]) begin
                n_fail++;
                $display("FAIL str cycle %0d: got %h expected %h", i, ctl, exp_v[i]);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_flags();
        logic [15:0] exp_v [4];
        // SUBS R0,R0,R0 with the ALU reporting Z
        exp_v[0] = cv(1, 0, 0, 1, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 2'b10);
        exp_v[1] = cv(0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 2'b10);
        exp_v[2] = cv(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00);
        exp_v[3] = cv(0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        Instr    = 20'hE0500;
        ALUFlags = 4'b0100;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ctl !== exp_v[i]) begin
                n_fail++;
                $display("FAIL subs cycle %0d: got %h expected %h", i, ctl, exp_v[i]);
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if (dut.u_cond.flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL subs_flags: got %b expected 0100", dut.u_cond.flags);
        end
        // ADDNE with Z set: no register write
        ALUFlags = 4'b1011;
        Instr    = 20'h10821;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL addne_regwrite: got %b expected 0", RegWrite);
        end
        @(negedge clk); #1;
        // ADDEQ with Z set: writes
        Instr = 20'h00821;
        #1;
        n_checks++;
        if (PCWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL addeq_fetch_pcwrite: got %b expected 1", PCWrite);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (RegWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL addeq_regwrite: got %b expected 1", RegWrite);
        end
        @(negedge clk); #1;
        n_checks++;
        if (dut.u_cond.flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL nonS_flags: got %b expected 0100", dut.u_cond.flags);
        end
    endtask

    task automatic test_cmp();
        logic [1:0] exp_ac;
        logic [3:0] exp_flags;
`ifdef CTRL_CMP_EN
        exp_ac    = 2'b01;
        exp_flags = 4'b1001;
`else
        exp_ac    = 2'b00;
        exp_flags = 4'b0100;
`endif
        Instr    = 20'hE1500;
        ALUFlags = 4'b1001;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (ALUControl !== exp_ac) begin
            n_fail++;
            $display("FAIL cmp_alucontrol: got %b expected %b", ALUControl, exp_ac);
        end
        @(negedge clk); #1;
        n_checks++;
        if (RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_regwrite: got %b expected 0", RegWrite);
        end
        n_checks++;
        if (dut.u_cond.flags !== exp_flags) begin
            n_fail++;
            $display("FAIL cmp_flags: got %b expected %b", dut.u_cond.flags, exp_flags);
        end
        @(negedge clk); #1;
        ALUFlags = 4'b0000;
    endtask

    task automatic test_undef();
        logic [15:0] exp_v [3];
        exp_v[0] = cv(1, 0, 0, 1, 2'b00, 0, 2'b11, 1, 2'b10, 2'b00, 2'b10);
        exp_v[1] = cv(0, 0, 0, 0, 2'b00, 0, 2'b11, 1, 2'b10, 2'b00, 2'b10);
        exp_v[2] = exp_v[0];
        Instr = 20'hEC000;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ctl !== exp_v[i]) begin
                n_fail++;
                $display("FAIL undef cycle %0d: got %h expected %h", i, ctl, exp_v[i]);
            end
            if (i < 2) begin
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic test_branch();
        logic [15:0] exp_v [4];
        exp_v[0] = cv(1, 0, 0, 1, 2'b01, 0, 2'b10, 1, 2'b10, 2'b00, 2'b10);
        exp_v[1] = cv(0, 0, 0, 0, 2'b01, 0, 2'b10, 1, 2'b10, 2'b00, 2'b10);
        exp_v[2] = cv(1, 0, 0, 0, 2'b01, 0, 2'b10, 0, 2'b01, 2'b00, 2'b10);
        exp_v[3] = exp_v[0];
        Instr = 20'hEA000;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ctl !== exp_v[i]) begin
                n_fail++;
                $display("FAIL branch cycle %0d: got %h expected %h", i, ctl, exp_v[i]);
            end
            if (i < 3) begin
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] exp_f, exp_d, exp_rd;
        exp_f  = cv(1, 0, 0, 1, 2'b10, 0, 2'b01, 1, 2'b10, 2'b00, 2'b10);
        exp_d  = cv(0, 0, 0, 0, 2'b10, 0, 2'b01, 1, 2'b10, 2'b00, 2'b10);
        exp_rd = cv(0, 1, 0, 0, 2'b10, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00);
        Instr = 20'hE5912;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (ctl !== exp_rd) begin
            n_fail++;
            $display("FAIL abort_memread: got %h expected %h", ctl, exp_rd);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (ctl !== exp_f) begin
            n_fail++;
            $display("FAIL abort_async_ctl: got %h expected %h", ctl, exp_f);
        end
        n_checks++;
        if (dut.u_cond.flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_async_flags: got %b expected 0000", dut.u_cond.flags);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({RegWrite, MemWrite} !== 2'b00 || ctl !== exp_f) begin
                n_fail++;
                $display("FAIL abort_hold %0d: got %h expected %h", i, ctl, exp_f);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (ctl !== exp_f) begin
            n_fail++;
            $display("FAIL abort_release_fetch: got %h expected %h", ctl, exp_f);
        end
        @(negedge clk); #1;
        n_checks++;
        if (ctl !== exp_d) begin
            n_fail++;
            $display("FAIL abort_resume_decode: got %h expected %h", ctl, exp_d);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldr();
        test_str();
        test_flags();
        test_cmp();
        test_undef();
        test_branch();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
